fetch_prefetch: RTL and testbench
=================================

Name: fetch_prefetch

Overview:
Instruction fetch unit for the pipelined SCHOLAR RISC-V core. It replaces the single-cycle fetch, which needed a 1-cycle memory hit and a stable PC. This block owns the PC, issues pipelined request/grant reads with up to MaxOutstanding requests in flight, and buffers returned instructions with their PCs in a Depth-entry FIFO. It presents a valid/ready stream to decode and supports redirects (branch/jump/trap) with flush and discard of stale responses.

Parameters:
AddrWidth, 32, address/PC width in bits
InstrWidth, 32, instruction width in bits; PC increment = InstrWidth/8
Depth, 4, prefetch FIFO entries; power of 2, >= 2
MaxOutstanding, 2, max granted-but-unreturned requests; 1..Depth
ResetVector, 0, PC loaded on reset (AddrWidth bits)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
redirect_i  in  1  load new fetch PC and flush
redirect_pc_i  in  AddrWidth  redirect target
instr_o  out  InstrWidth  instruction at FIFO head
pc_o  out  AddrWidth  PC of instr_o
valid_o  out  1  instr_o/pc_o valid
ready_i  in  1  decode accepts head
m_req_o  out  1  memory read request
m_addr_o  out  AddrWidth  memory read address
m_gnt_i  in  1  request accepted (same cycle as m_req_o)
m_rvalid_i  in  1  read data valid, in order, >= 1 cycle after grant
m_rdata_i  in  InstrWidth  read data

Behaviour:
- Reset is synchronous and active-high; the clock is clk_i.
- Reset values: fetch_pc = ResetVector, resp_pc = ResetVector, outstanding = 0, discard = 0, FIFO empty.
- Outputs during and just after reset: m_req_o = 0, valid_o = 0, instr_o = 0, pc_o = 0.
- Credit rule: m_req_o = !rst_i & !redirect_i & (outstanding < MaxOutstanding) & (outstanding + fifo_count < Depth). With this rule the FIFO never overflows.
- m_addr_o = fetch_pc. It is held stable while m_req_o=1 and m_gnt_i=0.
- On grant (m_req_o & m_gnt_i): fetch_pc += InstrWidth/8, modulo 2^AddrWidth; outstanding += 1.
- On response (m_rvalid_i): outstanding -= 1.
- If discard > 0: discard -= 1 and the data is dropped.
- Otherwise: push {m_rdata_i, resp_pc} and resp_pc += InstrWidth/8.
- Grant and response in the same cycle leave outstanding unchanged.
- Output stream:
  - valid_o = !fifo_empty & !redirect_i.
  - instr_o/pc_o come from the FIFO head and are 0 when the FIFO is empty.
  - Pop when valid_o & ready_i.
  - There is no bypass: a response pushed in cycle N is first visible in cycle N+1.
  - Minimum latency from grant to valid_o is 2 cycles.
  - Push and pop in the same cycle are allowed at any fill level.
- Redirect (redirect_i=1, a single cycle):
  - fetch_pc and resp_pc load redirect_pc_i with bits [1:0] forced to 0.
  - FIFO is flushed.
  - discard = outstanding minus (1 if a non-discarded m_rvalid_i arrives this cycle); pre-existing discard is accumulated.
  - No request is issued and no pop occurs.
  - The response arriving in the redirect cycle is dropped.
  - The first request to the new PC is issued in the cycle after the redirect.
- Back-to-back redirects: the last one wins, and the discard count stays correct.
- Reset mid-operation clears all state. The memory must be reset in the same cycle, so no responses to pre-reset grants arrive.
- outstanding never exceeds MaxOutstanding. A response with outstanding = 0 is a protocol error; flag it with a simulation assertion and ignore it.
- Elaboration error if Depth is not a power of 2, if MaxOutstanding is outside 1..Depth, or if InstrWidth is not 32.

Test Plan:
- Reset release, zero-latency-grant memory (gnt=1, rvalid 1 cycle after grant), ready_i=1 → m_addr_o sequence 0x0,0x4,0x8,…; first valid_o 2 cycles after first grant with pc_o=0x0; then one instruction per cycle, with pc_o equal to the data's address.
- ready_i=0 with Depth=4 → exactly 4 instructions buffered; m_req_o drops once outstanding + count = 4; on ready_i=1 they drain in order 0x0..0xC and fetching resumes at 0x10.
- Memory latency 3 cycles, MaxOutstanding=2 → never more than 2 ungranted-return requests; m_addr_o held while m_gnt_i=0 for 2 cycles; no data lost or reordered.
- Redirect to 0x100 with 2 outstanding (to 0x8, 0xC) and 2 buffered → FIFO empty next cycle; both stale responses dropped; next valid_o has pc_o=0x100 with the 0x100 data; redirect_pc_i=0x103 fetches 0x100.
- Redirect in the same cycle as a response and a pop, then a second redirect the next cycle → only the data of the second target appears, and its discard accounting is correct.
- fetch_pc at 0xFFFFFFFC → next request address 0x00000000; assert rst_i mid-stream → all outputs 0 the next cycle; fetch restarts at ResetVector.

Source files
------------

// File: rtl/fetch_prefetch.sv
// rtl/fetch_prefetch.sv - instruction fetch unit with pipelined request/grant reads and prefetch FIFO
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   redirect_i/_pc_i      load a new fetch PC and flush buffered/in-flight work
//   instr_o, pc_o,
//   valid_o, ready_i      decode-side stream from the FIFO head
//   m_req_o, m_addr_o,
//   m_gnt_i               memory read request channel (grant same cycle)
//   m_rvalid_i, m_rdata_i in-order read responses
module fetch_prefetch #(
    parameter int                   AddrWidth      = 32,
    parameter int                   InstrWidth     = 32,
    parameter int                   Depth          = 4,
    parameter int                   MaxOutstanding = 2,
    parameter logic [AddrWidth-1:0] ResetVector    = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  redirect_i,
    input  logic [AddrWidth-1:0]  redirect_pc_i,
    output logic [InstrWidth-1:0] instr_o,
    output logic [AddrWidth-1:0]  pc_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  m_req_o,
    output logic [AddrWidth-1:0]  m_addr_o,
    input  logic                  m_gnt_i,
    input  logic                  m_rvalid_i,
    input  logic [InstrWidth-1:0] m_rdata_i
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;
    localparam int OutW = $clog2(MaxOutstanding + 1);
    localparam logic [AddrWidth-1:0] PcInc = AddrWidth'(InstrWidth / 8);

    generate
        if ((Depth < 2) || ((Depth & (Depth - 1)) != 0)) begin : g_bad_depth
            $error("fetch_prefetch: Depth must be a power of 2 and >= 2");
        end
        if ((MaxOutstanding < 1) || (MaxOutstanding > Depth)) begin : g_bad_max_out
            $error("fetch_prefetch: MaxOutstanding must be in 1..Depth");
        end
        if (InstrWidth != 32) begin : g_bad_instr_width
            $error("fetch_prefetch: InstrWidth must be 32");
        end
    endgenerate

    logic [AddrWidth-1:0]  r_fetch_pc;
    logic [AddrWidth-1:0]  r_resp_pc;
    logic [OutW-1:0]       r_outstanding;
    logic [OutW-1:0]       r_discard;
    logic [InstrWidth-1:0] r_instr_mem [Depth];
    logic [AddrWidth-1:0]  r_pc_mem    [Depth];
    logic [PtrW-1:0]       r_wr_ptr;
    logic [PtrW-1:0]       r_rd_ptr;
    logic [CntW-1:0]       r_count;

    logic                  w_fifo_empty;
    logic                  w_credit;
    logic                  w_grant;
    logic                  w_resp;
    logic                  w_push;
    logic                  w_pop;
    logic [AddrWidth-1:0]  w_redirect_pc;

    assign w_fifo_empty  = (r_count == '0);
    assign w_redirect_pc = redirect_pc_i & ~AddrWidth'(3);

    // Counting in-flight requests against free FIFO slots reserves a slot for
    // every granted read, so a returning response always has room.
    assign w_credit = (32'(r_outstanding) < MaxOutstanding) &&
                      ((32'(r_outstanding) + 32'(r_count)) < Depth);

    assign m_req_o  = !rst_i && !redirect_i && w_credit;
    assign m_addr_o = r_fetch_pc;
    assign w_grant  = m_req_o && m_gnt_i;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_resp   = m_rvalid_i && (r_outstanding != '0);
    // Responses in a redirect cycle belong to the old stream and are dropped.
    assign w_push   = w_resp && (r_discard == '0) && !redirect_i;

    assign valid_o  = !w_fifo_empty && !redirect_i && !rst_i;
    assign w_pop    = valid_o && ready_i;
    assign instr_o  = (w_fifo_empty || rst_i) ? '0 : r_instr_mem[r_rd_ptr];
    assign pc_o     = (w_fifo_empty || rst_i) ? '0 : r_pc_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_pc    <= ResetVector;
            r_resp_pc     <= ResetVector;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_outstanding <= r_outstanding + OutW'(w_grant) - OutW'(w_resp);

            if (redirect_i) begin
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                // Every request still in flight after this cycle is stale;
                // this already covers any discards pending from earlier redirects.
                r_discard  <= r_outstanding - OutW'(w_resp);
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + PcInc;
                end
                if (w_resp && (r_discard != '0)) begin
                    r_discard <= r_discard - 1'b1;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + PcInc;
                    r_wr_ptr  <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
            end
        end
    end

    // Storage needs no reset: the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_push) begin
            r_instr_mem[r_wr_ptr] <= m_rdata_i;
            r_pc_mem[r_wr_ptr]    <= r_resp_pc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(m_rvalid_i && (r_outstanding == '0)));
            assert (32'(r_outstanding) <= MaxOutstanding);
        end
    end
endmodule

// File: tb/tb_fetch_prefetch.sv
// tb/tb_fetch_prefetch.sv - directed self-checking bench for fetch_prefetch
module tb_fetch_prefetch;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i;
    logic        m_req_o;
    logic [31:0] m_addr_o;
    logic        m_gnt_i;
    logic        m_rvalid_i;
    logic [31:0] m_rdata_i;

    always #5 clk_i = ~clk_i;

    fetch_prefetch #(
        .AddrWidth(32), .InstrWidth(32), .Depth(4), .MaxOutstanding(2), .ResetVector(32'h0)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .instr_o(instr_o), .pc_o(pc_o), .valid_o(valid_o), .ready_i(ready_i),
        .m_req_o(m_req_o), .m_addr_o(m_addr_o), .m_gnt_i(m_gnt_i),
        .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          mem_lat  = 1;
    logic        gnt_en   = 1'b1;
    int          max_q    = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] gnt_log[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_instr[$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_A5A5;
    endfunction

    function automatic bit resp_due();
        return (mq_addr.size() > 0) && (mq_due[0] <= cyc) && !rst_i;
    endfunction

    // One clock cycle: drive the memory model, log handshakes, advance to the next negedge.
    task automatic cycle();
        if (rst_i) begin
            mq_addr.delete();
            mq_due.delete();
        end
        m_gnt_i = gnt_en;
        if (resp_due()) begin
            m_rvalid_i = 1'b1;
            m_rdata_i  = mem_data(mq_addr[0]);
        end else begin
            m_rvalid_i = 1'b0;
            m_rdata_i  = '0;
        end
        #1;
        if (valid_o && ready_i) begin
            pop_pc.push_back(pc_o);
            pop_instr.push_back(instr_o);
        end
        if (m_rvalid_i) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (m_req_o && m_gnt_i) begin
            mq_addr.push_back(m_addr_o);
            mq_due.push_back(cyc + mem_lat);
            gnt_log.push_back(m_addr_o);
        end
        if (mq_addr.size() > max_q) max_q = mq_addr.size();
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic reset_dut();
        rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; ready_i = 1'b1; gnt_en = 1'b1;
        cycle();
        cycle();
        rst_i = 1'b0;
        gnt_log.delete(); pop_pc.delete(); pop_instr.delete();
        max_q = 0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; ready_i = 1'b1; gnt_en = 1'b1;
        cycle();
        cycle();
        n_checks++; if (m_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", m_req_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_checks++; if (instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr_o); end
        n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", pc_o); end
        rst_i = 1'b0;
        #1;
        n_checks++; if (m_req_o !== 1'b1 || m_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_release_req: got req=%b addr=%h want req=1 addr=0", m_req_o, m_addr_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid: got %b want 0", valid_o); end
    endtask

    task automatic test_stream();
        reset_dut();
        mem_lat = 1; ready_i = 1'b1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_c0_valid: got %b want 0", valid_o); end
        cycle();
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_c1_valid: got %b want 0", valid_o); end
        cycle();
        n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== mem_data(32'h0)) begin n_fail++; $display("FAIL stream_first: got v=%b pc=%h instr=%h want v=1 pc=0 instr=%h", valid_o, pc_o, instr_o, mem_data(32'h0)); end
        for (int k = 1; k <= 8; k++) begin
            cycle();
            n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'(4 * k) || instr_o !== mem_data(32'(4 * k))) begin n_fail++; $display("FAIL stream_seq%0d: got v=%b pc=%h instr=%h want v=1 pc=%h", k, valid_o, pc_o, instr_o, 32'(4 * k)); end
        end
        n_checks++; if (gnt_log.size() < 5) begin n_fail++; $display("FAIL stream_grants: got %0d grants want >= 5", gnt_log.size()); end
        else for (int k = 0; k < 5; k++) begin
            n_checks++; if (gnt_log[k] !== 32'(4 * k)) begin n_fail++; $display("FAIL stream_addr%0d: got %h want %h", k, gnt_log[k], 32'(4 * k)); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        reset_dut();
        mem_lat = 1; ready_i = 1'b0;
        for (int k = 0; k < 8; k++) cycle();
        n_checks++; if (m_req_o !== 1'b0) begin n_fail++; $display("FAIL bp_req_stall: got %b want 0", m_req_o); end
        n_checks++; if (gnt_log.size() != 4) begin n_fail++; $display("FAIL bp_grant_count: got %0d want 4", gnt_log.size()); end
        n_checks++; if (m_addr_o !== 32'h10) begin n_fail++; $display("FAIL bp_addr_hold: got %h want 00000010", m_addr_o); end
        n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0) begin n_fail++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0", valid_o, pc_o); end
        ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++; if (valid_o !== 1'b1 || pc_o !== exp_pc[k] || instr_o !== mem_data(exp_pc[k])) begin n_fail++; $display("FAIL bp_drain%0d: got v=%b pc=%h instr=%h want pc=%h", k, valid_o, pc_o, instr_o, exp_pc[k]); end
            cycle();
        end
        n_checks++; if (gnt_log.size() < 5 || gnt_log[4] !== 32'h10) begin n_fail++; $display("FAIL bp_resume: got %0d grants, fifth=%h want 00000010", gnt_log.size(), (gnt_log.size() >= 5) ? gnt_log[4] : 32'hx); end
    endtask

    task automatic test_latency();
        reset_dut();
        mem_lat = 3; ready_i = 1'b1; gnt_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++; if (m_req_o !== 1'b1 || m_addr_o !== 32'h0) begin n_fail++; $display("FAIL lat_hold%0d: got req=%b addr=%h want req=1 addr=0", k, m_req_o, m_addr_o); end
            cycle();
        end
        gnt_en = 1'b1;
        #1;
        n_checks++; if (m_req_o !== 1'b1 || m_addr_o !== 32'h0) begin n_fail++; $display("FAIL lat_hold_release: got req=%b addr=%h want req=1 addr=0", m_req_o, m_addr_o); end
        for (int k = 0; k < 30; k++) begin
            gnt_en = (k % 3 != 2);
            cycle();
        end
        n_checks++; if (max_q != 2) begin n_fail++; $display("FAIL lat_max_outstanding: got %0d want 2", max_q); end
        n_checks++; if (pop_pc.size() < 6) begin n_fail++; $display("FAIL lat_pop_count: got %0d want >= 6", pop_pc.size()); end
        for (int i = 0; i < pop_pc.size(); i++) begin
            n_checks++; if (pop_pc[i] !== 32'(4 * i) || pop_instr[i] !== mem_data(32'(4 * i))) begin n_fail++; $display("FAIL lat_order%0d: got pc=%h instr=%h want pc=%h", i, pop_pc[i], pop_instr[i], 32'(4 * i)); end
        end
    endtask

    task automatic test_redirect();
        reset_dut();
        mem_lat = 2; ready_i = 1'b0;
        for (int k = 0; k < 5; k++) cycle();
        n_checks++; if (mq_addr.size() != 2 || mq_addr[0] !== 32'h8) begin n_fail++; $display("FAIL redir_inflight: got %0d in flight want 2 starting at 00000008", mq_addr.size()); end
        n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0) begin n_fail++; $display("FAIL redir_pre_head: got v=%b pc=%h want v=1 pc=0", valid_o, pc_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'h103; ready_i = 1'b1;
        #1;
        n_checks++; if (valid_o !== 1'b0 || m_req_o !== 1'b0) begin n_fail++; $display("FAIL redir_cycle: got v=%b req=%b want 0 0", valid_o, m_req_o); end
        cycle();
        redirect_i = 1'b0;
        #1;
        n_checks++; if (valid_o !== 1'b0 || m_req_o !== 1'b1 || m_addr_o !== 32'h100) begin n_fail++; $display("FAIL redir_after: got v=%b req=%b addr=%h want v=0 req=1 addr=00000100", valid_o, m_req_o, m_addr_o); end
        for (int k = 0; k < 6; k++) cycle();
        n_checks++; if (pop_pc.size() < 2) begin n_fail++; $display("FAIL redir_pop_count: got %0d want >= 2", pop_pc.size()); end
        else begin
            n_checks++; if (pop_pc[0] !== 32'h100 || pop_instr[0] !== mem_data(32'h100)) begin n_fail++; $display("FAIL redir_first: got pc=%h instr=%h want pc=00000100 instr=%h", pop_pc[0], pop_instr[0], mem_data(32'h100)); end
            n_checks++; if (pop_pc[1] !== 32'h104 || pop_instr[1] !== mem_data(32'h104)) begin n_fail++; $display("FAIL redir_second: got pc=%h instr=%h want pc=00000104", pop_pc[1], pop_instr[1]); end
        end
    endtask

    task automatic test_back_to_back();
        bit found;
        int n;
        reset_dut();
        mem_lat = 2; ready_i = 1'b1;
        for (int k = 0; k < 6; k++) cycle();
        found = 1'b0;
        for (int t = 0; t < 10 && !found; t++) begin
            #1;
            if (resp_due() && valid_o) found = 1'b1;
            else cycle();
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL b2b_setup: got no cycle with response and pop within 10 cycles"); end
        redirect_i = 1'b1; redirect_pc_i = 32'h200;
        #1;
        n_checks++; if (valid_o !== 1'b0 || m_req_o !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got v=%b req=%b want 0 0", valid_o, m_req_o); end
        n = pop_pc.size();
        cycle();
        redirect_pc_i = 32'h300;
        #1;
        n_checks++; if (valid_o !== 1'b0 || m_req_o !== 1'b0) begin n_fail++; $display("FAIL b2b_second: got v=%b req=%b want 0 0", valid_o, m_req_o); end
        cycle();
        redirect_i = 1'b0;
        for (int k = 0; k < 12; k++) cycle();
        n_checks++; if (pop_pc.size() < n + 3) begin n_fail++; $display("FAIL b2b_pop_count: got %0d want >= %0d", pop_pc.size(), n + 3); end
        else for (int i = 0; i < 3; i++) begin
            n_checks++; if (pop_pc[n + i] !== 32'h300 + 32'(4 * i) || pop_instr[n + i] !== mem_data(32'h300 + 32'(4 * i))) begin n_fail++; $display("FAIL b2b_seq%0d: got pc=%h instr=%h want pc=%h", i, pop_pc[n + i], pop_instr[n + i], 32'h300 + 32'(4 * i)); end
        end
    endtask

    task automatic test_wrap_and_reset();
        reset_dut();
        mem_lat = 1; ready_i = 1'b1;
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        cycle();
        redirect_i = 1'b0;
        #1;
        n_checks++; if (m_req_o !== 1'b1 || m_addr_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_start: got req=%b addr=%h want req=1 addr=fffffffc", m_req_o, m_addr_o); end
        cycle();
        n_checks++; if (m_addr_o !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got %h want 00000000", m_addr_o); end
        for (int k = 0; k < 4; k++) cycle();
        n_checks++; if (pop_pc.size() < 2 || pop_pc[0] !== 32'hFFFF_FFFC || pop_pc[1] !== 32'h0) begin n_fail++; $display("FAIL wrap_pops: got %0d pops, first=%h want fffffffc then 00000000", pop_pc.size(), (pop_pc.size() > 0) ? pop_pc[0] : 32'hx); end
        rst_i = 1'b1;
        #1;
        n_checks++; if (m_req_o !== 1'b0 || valid_o !== 1'b0 || pc_o !== 32'h0 || instr_o !== 32'h0) begin n_fail++; $display("FAIL midreset_during: got req=%b v=%b pc=%h instr=%h want all 0", m_req_o, valid_o, pc_o, instr_o); end
        cycle();
        rst_i = 1'b0;
        pop_pc.delete(); pop_instr.delete();
        #1;
        n_checks++; if (valid_o !== 1'b0 || pc_o !== 32'h0 || instr_o !== 32'h0) begin n_fail++; $display("FAIL midreset_after: got v=%b pc=%h instr=%h want all 0", valid_o, pc_o, instr_o); end
        n_checks++; if (m_req_o !== 1'b1 || m_addr_o !== 32'h0) begin n_fail++; $display("FAIL midreset_restart: got req=%b addr=%h want req=1 addr=0", m_req_o, m_addr_o); end
        for (int k = 0; k < 5; k++) cycle();
        n_checks++; if (pop_pc.size() < 1 || pop_pc[0] !== 32'h0 || pop_instr[0] !== mem_data(32'h0)) begin n_fail++; $display("FAIL midreset_first_pop: got %0d pops, first=%h want 00000000", pop_pc.size(), (pop_pc.size() > 0) ? pop_pc[0] : 32'hx); end
    endtask

    initial begin
        rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; ready_i = 1'b1;
        m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = '0;
        @(negedge clk_i);
        test_reset();
        test_stream();
        test_backpressure();
        test_latency();
        test_redirect();
        test_back_to_back();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
